// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multicycle MIPS control unit:
// ALU operation codes, opcode/funct constants, datapath select encodings,
// FSM state encoding and the ALU-decoder class selector.
package multicycle_control_unit_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_LUI = 4'b0010,
        ALU_ADD = 4'b0011,
        ALU_SLL = 4'b0100,
        ALU_NOR = 4'b0101,
        ALU_SRL = 4'b0110,
        ALU_SUB = 4'b0111
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;

    localparam logic [1:0] SRCA_PC   = 2'd0;
    localparam logic [1:0] SRCA_REGA = 2'd1;
    localparam logic [1:0] SRCA_REGB = 2'd2;

    localparam logic [2:0] SRCB_REGB    = 3'd0;
    localparam logic [2:0] SRCB_FOUR    = 3'd1;
    localparam logic [2:0] SRCB_SIMM    = 3'd2;
    localparam logic [2:0] SRCB_SIMM_SH = 3'd3;
    localparam logic [2:0] SRCB_ZIMM    = 3'd4;
    localparam logic [2:0] SRCB_SHAMT   = 3'd5;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_R_WB, S_EXEC_I, S_I_WB,
        S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
        S_BRANCH, S_JUMP, S_HALT
    } state_e;

    // Which rule the ALU decoder applies in the current state.
    typedef enum logic [1:0] {
        CLS_ADD, CLS_SUB, CLS_R, CLS_I
    } alu_cls_e;

endpackage

// File: rtl/multicycle_control_unit_alu_control_decoder.sv
// ALU control decoder (combinational).
//   i_opcode/i_funct : instruction fields from the IR
//   i_cls            : fixed ADD, fixed SUB, R-type (by funct) or I-type (by opcode)
//   o_alu_op         : ALU operation code
//   o_legal          : funct/opcode is supported for the selected class
//   o_shift          : R-type shift (operands come from rt and shamt)
module alu_control_decoder
    import multicycle_control_unit_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  alu_cls_e   i_cls,
    output logic [3:0] o_alu_op,
    output logic       o_legal,
    output logic       o_shift
);
    always_comb begin
        o_alu_op = ALU_ADD;
        o_legal  = 1'b1;
        o_shift  = 1'b0;
        case (i_cls)
            CLS_ADD: o_alu_op = ALU_ADD;
            CLS_SUB: o_alu_op = ALU_SUB;
            CLS_R: begin
                case (i_funct)
                    FN_ADD:  o_alu_op = ALU_ADD;
                    FN_SUB:  o_alu_op = ALU_SUB;
                    FN_AND:  o_alu_op = ALU_AND;
                    FN_OR:   o_alu_op = ALU_OR;
                    FN_NOR:  o_alu_op = ALU_NOR;
                    FN_SLL: begin o_alu_op = ALU_SLL; o_shift = 1'b1; end
                    FN_SRL: begin o_alu_op = ALU_SRL; o_shift = 1'b1; end
                    default: o_legal = 1'b0;
                endcase
            end
            CLS_I: begin
                case (i_opcode)
                    OP_ADDI: o_alu_op = ALU_ADD;
                    OP_ANDI: o_alu_op = ALU_AND;
                    OP_ORI:  o_alu_op = ALU_OR;
                    OP_LUI:  o_alu_op = ALU_LUI;
                    default: o_legal = 1'b0;
                endcase
            end
            default: o_alu_op = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM controller for the multicycle MIPS datapath.
//   clk, reset(async, active low), opcode/funct from the IR, zero from the ALU,
//   mem_ready from memory. Outputs drive ALU op, operand selects, memory
//   strobes, IR/PC/register-file enables and the halted flag.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] alu_operation,
    output logic [1:0] alu_src_a,
    output logic [2:0] alu_src_b,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       halted
);
    localparam state_e ILLEGAL_NEXT = ILLEGAL_HALT ? S_HALT : S_FETCH;

    state_e     r_state, w_next;
    alu_cls_e   w_cls;
    logic       w_alu_en, w_legal, w_shift;
    logic [3:0] w_dec_op;
    logic [1:0] w_src_a, w_pc_source;
    logic [2:0] w_src_b;
    logic       w_i_or_d, w_mem_read, w_mem_write, w_ir_write, w_pc_write;
    logic       w_reg_write, w_reg_dst, w_mem_to_reg, w_halted;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // Decoder class depends only on state, kept apart from the main
    // process so the decoder sits outside the next-state loop.
    always_comb begin
        w_cls    = CLS_ADD;
        w_alu_en = 1'b0;
        case (r_state)
            S_FETCH, S_DECODE, S_MEM_ADDR: w_alu_en = 1'b1;
            S_BRANCH: begin w_cls = CLS_SUB; w_alu_en = 1'b1; end
            S_EXEC_R: begin w_cls = CLS_R;   w_alu_en = 1'b1; end
            S_EXEC_I: begin w_cls = CLS_I;   w_alu_en = 1'b1; end
            default: ;
        endcase
    end

    alu_control_decoder u_alu_dec (
        .i_opcode (opcode),
        .i_funct  (funct),
        .i_cls    (w_cls),
        .o_alu_op (w_dec_op),
        .o_legal  (w_legal),
        .o_shift  (w_shift)
    );

    always_comb begin
        w_next       = S_FETCH;
        w_src_a      = SRCA_PC;
        w_src_b      = SRCB_REGB;
        w_pc_source  = PCSRC_ALU;
        w_i_or_d     = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_halted     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                w_src_b    = SRCB_FOUR;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                w_src_b = SRCB_SIMM_SH;
                case (opcode)
                    OP_RTYPE:                      w_next = S_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: w_next = S_EXEC_I;
                    OP_LW, OP_SW:                  w_next = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                w_next = S_BRANCH;
                    OP_J:                          w_next = S_JUMP;
                    default:                       w_next = ILLEGAL_NEXT;
                endcase
            end
            S_EXEC_R: begin
                w_src_a = w_shift ? SRCA_REGB  : SRCA_REGA;
                w_src_b = w_shift ? SRCB_SHAMT : SRCB_REGB;
                w_next  = w_legal ? S_R_WB : ILLEGAL_NEXT;
            end
            S_R_WB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
            end
            S_EXEC_I: begin
                w_src_a = SRCA_REGA;
                w_src_b = (opcode == OP_ADDI) ? SRCB_SIMM : SRCB_ZIMM;
                w_next  = S_I_WB;
            end
            S_I_WB:     w_reg_write = 1'b1;
            S_MEM_ADDR: begin
                w_src_a = SRCA_REGA;
                w_src_b = SRCB_SIMM;
                w_next  = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                w_mem_read = 1'b1;
                w_i_or_d   = 1'b1;
                w_next     = mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                w_mem_write = 1'b1;
                w_i_or_d    = 1'b1;
                w_next      = mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_BRANCH: begin
                w_src_a     = SRCA_REGA;
                w_pc_source = PCSRC_ALUOUT;
                w_pc_write  = (opcode == OP_BNE) ? ~zero : zero;
            end
            S_JUMP: begin
                w_pc_source = PCSRC_JUMP;
                w_pc_write  = 1'b1;
            end
            S_HALT: begin
                w_halted = 1'b1;
                w_next   = S_HALT;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Reset gates every output combinationally so a mid-access abort drops
    // strobes immediately, not at the next clock.
    assign alu_operation = (reset && w_alu_en) ? w_dec_op : 4'd0;
    assign alu_src_a     = reset ? w_src_a      : 2'd0;
    assign alu_src_b     = reset ? w_src_b      : 3'd0;
    assign pc_source     = reset ? w_pc_source  : 2'd0;
    assign i_or_d        = reset & w_i_or_d;
    assign mem_read      = reset & w_mem_read;
    assign mem_write     = reset & w_mem_write;
    assign ir_write      = reset & w_ir_write;
    assign pc_write      = reset & w_pc_write;
    assign reg_write     = reset & w_reg_write;
    assign reg_dst       = reset & w_reg_dst;
    assign mem_to_reg    = reset & w_mem_to_reg;
    assign halted        = reset & w_halted;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

    typedef struct packed {
        logic [3:0] alu;
        logic [1:0] sa;
        logic [2:0] sb;
        logic       iord, mr, mw, irw, pcw;
        logic [1:0] pcs;
        logic       rw, rd, m2r, hlt;
    } obs_t;

    localparam logic [3:0] A_ADD = 4'b0011, A_SUB = 4'b0111, A_AND = 4'b0000, A_OR = 4'b0001;
    localparam logic [3:0] A_NOR = 4'b0101, A_LUI = 4'b0010, A_SLL = 4'b0100, A_SRL = 4'b0110;

    logic       clk = 1'b0, reset = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic [5:0] opcode = 6'h0, funct = 6'h0;

    logic [3:0] h_alu, n_alu;
    logic [1:0] h_sa, n_sa, h_pcs, n_pcs;
    logic [2:0] h_sb, n_sb;
    logic h_iord, h_mr, h_mw, h_irw, h_pcw, h_rw, h_rd, h_m2r, h_hlt;
    logic n_iord, n_mr, n_mw, n_irw, n_pcw, n_rw, n_rd, n_m2r, n_hlt;
    obs_t h_obs, n_obs;

    int total = 0, bad = 0;

    obs_t qh[$], qn[$];
    bit   qmr[$], qck[$];

    always #5 clk = ~clk;

    multicycle_control_unit #(.ILLEGAL_HALT(1'b1)) dut_h (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .alu_operation(h_alu), .alu_src_a(h_sa), .alu_src_b(h_sb),
        .i_or_d(h_iord), .mem_read(h_mr), .mem_write(h_mw), .ir_write(h_irw),
        .pc_write(h_pcw), .pc_source(h_pcs), .reg_write(h_rw), .reg_dst(h_rd),
        .mem_to_reg(h_m2r), .halted(h_hlt));

    multicycle_control_unit #(.ILLEGAL_HALT(1'b0)) dut_n (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .alu_operation(n_alu), .alu_src_a(n_sa), .alu_src_b(n_sb),
        .i_or_d(n_iord), .mem_read(n_mr), .mem_write(n_mw), .ir_write(n_irw),
        .pc_write(n_pcw), .pc_source(n_pcs), .reg_write(n_rw), .reg_dst(n_rd),
        .mem_to_reg(n_m2r), .halted(n_hlt));

    assign h_obs = '{h_alu, h_sa, h_sb, h_iord, h_mr, h_mw, h_irw, h_pcw, h_pcs, h_rw, h_rd, h_m2r, h_hlt};
    assign n_obs = '{n_alu, n_sa, n_sb, n_iord, n_mr, n_mw, n_irw, n_pcw, n_pcs, n_rw, n_rd, n_m2r, n_hlt};

    // ---------------- reference model: per-instruction cycle script ----------------
    function automatic obs_t fetch_obs();
        obs_t e = '0;
        e.mr = 1'b1; e.sb = 3'd1; e.alu = A_ADD;
        return e;
    endfunction

    function automatic bit r_alu(input logic [5:0] fn, output logic [3:0] op, output bit shift);
        shift = 1'b0; op = A_ADD;
        case (fn)
            6'h20: op = A_ADD;
            6'h22: op = A_SUB;
            6'h24: op = A_AND;
            6'h25: op = A_OR;
            6'h27: op = A_NOR;
            6'h00: begin op = A_SLL; shift = 1'b1; end
            6'h02: begin op = A_SRL; shift = 1'b1; end
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    task automatic push(input obs_t eh, input obs_t en, input bit mr, input bit ck);
        qh.push_back(eh); qn.push_back(en); qmr.push_back(mr); qck.push_back(ck);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        reset = 1'b0; mem_ready = 1'b1; opcode = 6'($urandom); funct = 6'($urandom);
        #1;
        total++; if (h_obs !== '0) begin bad++; $display("FAIL %s rst_h got=%h want=0", name, h_obs); end
        total++; if (n_obs !== '0) begin bad++; $display("FAIL %s rst_n got=%h want=0", name, n_obs); end
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b0;
        #1;
        total++; if (h_obs !== fetch_obs()) begin bad++; $display("FAIL %s rel_h got=%h want=%h", name, h_obs, fetch_obs()); end
        total++; if (n_obs !== fetch_obs()) begin bad++; $display("FAIL %s rel_n got=%h want=%h", name, n_obs, fetch_obs()); end
    endtask

    // Builds the expected cycle sequence for one instruction from the ISA
    // description, then drives it and compares both controller variants.
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int fw, input int mw);
        obs_t e, eh, en;
        bit illegal = 1'b0, shift;
        logic [3:0] aop;
        qh.delete(); qn.delete(); qmr.delete(); qck.delete();
        for (int i = 0; i < fw; i++) push(fetch_obs(), fetch_obs(), 1'b0, 1'b1);
        e = fetch_obs(); e.irw = 1'b1; e.pcw = 1'b1;
        push(e, e, 1'b1, 1'b1);
        e = '0; e.sb = 3'd3; e.alu = A_ADD;
        push(e, e, 1'($urandom), 1'b1);
        case (op)
            6'h00: begin
                if (r_alu(fn, aop, shift)) begin
                    e = '0; e.alu = aop;
                    e.sa = shift ? 2'd2 : 2'd1; e.sb = shift ? 3'd5 : 3'd0;
                    push(e, e, 1'($urandom), 1'b1);
                    e = '0; e.rw = 1'b1; e.rd = 1'b1;
                    push(e, e, 1'($urandom), 1'b1);
                end else begin
                    push('0, '0, 1'b0, 1'b0);
                    illegal = 1'b1;
                end
            end
            6'h08, 6'h0C, 6'h0D, 6'h0F: begin
                e = '0; e.sa = 2'd1;
                e.sb  = (op == 6'h08) ? 3'd2 : 3'd4;
                e.alu = (op == 6'h08) ? A_ADD : (op == 6'h0C) ? A_AND : (op == 6'h0D) ? A_OR : A_LUI;
                push(e, e, 1'($urandom), 1'b1);
                e = '0; e.rw = 1'b1;
                push(e, e, 1'($urandom), 1'b1);
            end
            6'h23, 6'h2B: begin
                e = '0; e.sa = 2'd1; e.sb = 3'd2; e.alu = A_ADD;
                push(e, e, 1'($urandom), 1'b1);
                e = '0; e.iord = 1'b1;
                if (op == 6'h23) e.mr = 1'b1; else e.mw = 1'b1;
                for (int i = 0; i < mw; i++) push(e, e, 1'b0, 1'b1);
                push(e, e, 1'b1, 1'b1);
                if (op == 6'h23) begin
                    e = '0; e.rw = 1'b1; e.m2r = 1'b1;
                    push(e, e, 1'($urandom), 1'b1);
                end
            end
            6'h04, 6'h05: begin
                e = '0; e.sa = 2'd1; e.alu = A_SUB; e.pcs = 2'd1;
                e.pcw = (op == 6'h04) ? z : ~z;
                push(e, e, 1'($urandom), 1'b1);
            end
            6'h02: begin
                e = '0; e.pcs = 2'd2; e.pcw = 1'b1;
                push(e, e, 1'($urandom), 1'b1);
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            // The halting variant sits in HALT; the other one is back in
            // FETCH waiting on memory.
            eh = '0; eh.hlt = 1'b1;
            en = fetch_obs();
            for (int i = 0; i < 20; i++) push(eh, en, 1'b0, 1'b1);
        end
        for (int i = 0; i < qh.size(); i++) begin
            @(negedge clk);
            opcode = op; funct = fn; zero = z; mem_ready = qmr[i];
            #1;
            if (qck[i]) begin
                total++;
                if (h_obs !== qh[i]) begin bad++; $display("FAIL %s cyc%0d halt1 got=%h want=%h", name, i, h_obs, qh[i]); end
                total++;
                if (n_obs !== qn[i]) begin bad++; $display("FAIL %s cyc%0d halt0 got=%h want=%h", name, i, n_obs, qn[i]); end
            end
        end
        if (illegal) do_reset({name, "_rst"});
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        do_reset("reset");
    endtask

    task automatic test_add();   run_instr("add", 6'h00, 6'h20, 1'b0, 0, 0); endtask
    task automatic test_sll();   run_instr("sll", 6'h00, 6'h00, 1'b0, 1, 0); endtask
    task automatic test_lui();   run_instr("lui", 6'h0F, 6'h15, 1'b0, 0, 0); endtask
    task automatic test_lw_wait(); run_instr("lw_wait", 6'h23, 6'h11, 1'b0, 2, 3); endtask

    task automatic test_branch();
        run_instr("beq_z1", 6'h04, 6'h00, 1'b1, 0, 0);
        run_instr("beq_z0", 6'h04, 6'h00, 1'b0, 0, 0);
        run_instr("bne_z1", 6'h05, 6'h00, 1'b1, 0, 0);
        run_instr("bne_z0", 6'h05, 6'h00, 1'b0, 0, 0);
        run_instr("jump",   6'h02, 6'h00, 1'b0, 0, 0);
    endtask

    task automatic test_illegal();
        run_instr("illegal_op", 6'h3F, 6'h20, 1'b0, 0, 0);
        run_instr("illegal_fn", 6'h00, 6'h21, 1'b0, 0, 0);
    endtask

    task automatic test_sw_abort();
        obs_t e;
        @(negedge clk); opcode = 6'h2B; mem_ready = 1'b1;   // FETCH
        @(negedge clk); mem_ready = 1'b0;                   // DECODE
        @(negedge clk);                                     // MEM_ADDR
        @(negedge clk);                                     // MEM_WRITE, memory busy
        #1;
        total++; if (h_mw !== 1'b1) begin bad++; $display("FAIL sw_abort pre got=%b want=1", h_mw); end
        #2 reset = 1'b0;
        #1;
        total++; if (h_mw !== 1'b0) begin bad++; $display("FAIL sw_abort mw got=%b want=0", h_mw); end
        total++; if (n_obs !== '0) begin bad++; $display("FAIL sw_abort all got=%h want=0", n_obs); end
        @(negedge clk); reset = 1'b1;
        #1;
        e = fetch_obs();
        total++; if (h_obs !== e) begin bad++; $display("FAIL sw_abort restart got=%h want=%h", h_obs, e); end
    endtask

    task automatic test_random();
        logic [5:0] legal_op[10] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
        logic [5:0] legal_fn[7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02};
        logic [5:0] op, fn;
        for (int n = 0; n < 40; n++) begin
            op = legal_op[$urandom_range(0, 9)];
            fn = legal_fn[$urandom_range(0, 6)];
            if ($urandom_range(0, 9) == 0) fn = 6'h21;
            if ($urandom_range(0, 14) == 0) op = 6'h3E;
            run_instr("random", op, fn, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sll();
        test_lui();
        test_lw_wait();
        test_branch();
        test_illegal();
        test_sw_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
